mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 16-bit pipelined CPU, sitting between the EX/MEM pipeline register and `MEM_WB_Register`. It passes ALU results straight through for non-memory instructions and runs a req/ack transaction on the data-memory bus for loads and stores. While a transaction is in flight it stalls the upstream pipeline and inserts bubbles into MEM/WB. Its `result_out`, `reg_addr_out` and `write_enable_out` connect one-to-one to the `MEM_WB_Register` inputs.

## Interface
- `DATA_W`, 16, data/address width
- `REG_AW`, 4, register-address width
- `TIMEOUT_CYC`, 15, cycles `mem_req` may wait for `mem_ack` before abort (only with timeout compiled in)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `valid_in`  in  1  EX/MEM holds a real instruction
- `alu_result_in`  in  16  ALU result; memory address for loads/stores
- `store_data_in`  in  16  store data
- `reg_addr_in`  in  4  destination register
- `write_enable_in`  in  1  instruction writes the register file
- `mem_read_in`  in  1  load
- `mem_write_in`  in  1  store
- `stall`  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- `mem_req`, `mem_we`  out  1  bus request; write strobe
- `mem_addr`, `mem_wdata`  out  16  bus address; bus write data
- `mem_rdata`  in  16  read data, valid with `mem_ack`
- `mem_ack`  in  1  transaction complete
- `result_out`  out  16  to MEM/WB
- `reg_addr_out`  out  4  to MEM/WB
- `write_enable_out`  out  1  to MEM/WB
- `mem_err`  out  1  sticky bus-timeout flag

## Operation
- FSM states: IDLE, REQ, DONE (encoding in the package).
- IDLE, no memory op (`valid_in & (mem_read_in | mem_write_in)` false): pass-through. `result_out = alu_result_in`, `reg_addr_out = reg_addr_in`, `write_enable_out = valid_in & write_enable_in`, `stall = 0`.
- IDLE, memory op: `stall = 1`, `write_enable_out = 0`. Register `mem_addr`, `mem_wdata`, `mem_we = mem_write_in`. Next state REQ.
- REQ: `mem_req = 1`, `stall = 1`, `write_enable_out = 0`. Bus outputs are held stable.
  - `mem_ack` sampled high: for loads, capture `mem_rdata` into `load_buf`. Next state DONE, `mem_req` drops.
- DONE: `stall = 0`. `result_out = load_buf` for a load, `alu_result_in` for a store. `write_enable_out = write_enable_in`. Next state IDLE.
- `mem_read_in` and `mem_write_in` both set: treated as a store.
- `mem_ack` outside REQ is ignored.
- `reg_addr_out` always follows `reg_addr_in`.

## Timing
- Non-memory op: 0 extra cycles; outputs are combinational from inputs.
- Memory op with `mem_ack` on the first REQ cycle occupies 3 cycles (IDLE, REQ, DONE) and asserts `stall` for 2 of them. Each cycle `mem_ack` is late adds 1 more stall cycle.
- Reset values, registered on the edge that samples `reset`: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `load_buf` 0, `mem_err` 0.
- While `reset` is high, `stall` and `write_enable_out` are forced to 0.
- Reset during REQ aborts the transaction. `mem_req` is low in the cycle after reset is sampled, and the aborted op is never written back.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs in REQ. If `TIMEOUT_CYC` consecutive REQ cycles pass without `mem_ack`, the transaction aborts: next state DONE, `load_buf = 16'hDEAD`, `mem_err` set (sticky until reset).
  - The counter clears on entering REQ.
- `MEM_TIMEOUT_EN` undefined: REQ waits indefinitely and `mem_err` is tied 0.

## Structure
- `mem_stage_pkg` holds:
  - the state enum;
  - `DATA_W` and `REG_AW` defaults;
  - `MEM_ABORT_DATA = 16'hDEAD`.
- One sub-module, `mem_watchdog`, holds the timeout counter. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- ALU op: `alu_result_in = 16'h00AB`, `reg_addr_in = 4'b1010`, `write_enable_in = 1`, no mem op -> same-cycle `result_out = 00AB`, `write_enable_out = 1`, `stall = 0`.
- Load from address `0x0010`, memory acks on the first REQ cycle with `16'h1234` -> `stall` high for 2 cycles, then `result_out = 1234`, `write_enable_out = 1`, `reg_addr_out = 4'b1001`.
- Store `16'h00FF` to `0x0020`, ack delayed 3 cycles -> `mem_we = 1`, address and data stable throughout REQ, `stall` high for 5 cycles, `write_enable_out = 0` throughout.
- `reset` asserted on the second REQ cycle of a load -> next cycle `mem_req = 0`, state IDLE, no write-back, a late ack is ignored.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYC = 15`, no ack -> abort after 15 REQ cycles, `result_out = DEAD`, `mem_err = 1` held until reset.
- Back-to-back load then ALU op -> the ALU op passes through in the cycle after DONE with `stall = 0`.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the CPU memory-access stage.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;

  // Value returned to the register file when a bus transaction times out
  localparam logic [15:0] MEM_ABORT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Bus-timeout counter for mem_access_stage; only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_watchdog #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive REQ cycles; any non-REQ cycle clears it for the next transaction
  always_comb begin
    cnt_d = '0;
    if (active_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = active_i & ~ack_i & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU pass-through plus req/ack data-bus transactions with pipeline stall.
// Optional bus timeout with sticky error flag when MEM_TIMEOUT_EN is defined.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_AW-1:0] reg_addr_in,
  input  logic              write_enable_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] result_out,
  output logic [REG_AW-1:0] reg_addr_out,
  output logic              write_enable_out,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_buf_q, load_buf_d;
  logic              we_q, we_d;
  logic              mem_op;
  logic              abort;

  assign mem_op = valid_in & (mem_read_in | mem_write_in);

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .active_i  (state_q == ST_REQ),
    .ack_i     (mem_ack),
    .expired_o (abort)
  );

  always_ff @(posedge clk) begin
    if (reset)      err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      load_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      load_buf_q <= load_buf_d;
    end
  end

  // A set store bit wins over a set load bit, so we_q also marks "not a load"
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    load_buf_d = load_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          addr_d  = alu_result_in;
          wdata_d = store_data_in;
          we_d    = mem_write_in;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!we_q) load_buf_d = mem_rdata;
          state_d = ST_DONE;
        end else if (abort) begin
          load_buf_d = DATA_W'(MEM_ABORT_DATA);
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result_out       = alu_result_in;
    stall            = 1'b0;
    write_enable_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall            = mem_op;
        write_enable_out = valid_in & write_enable_in & ~mem_op;
      end
      ST_REQ:  stall = 1'b1;
      ST_DONE: begin
        write_enable_out = write_enable_in;
        if (!we_q) result_out = load_buf_q;
      end
      default: ;
    endcase
    if (reset) begin
      stall            = 1'b0;
      write_enable_out = 1'b0;
    end
  end

  assign reg_addr_out = reg_addr_in;
  assign mem_req      = (state_q == ST_REQ);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule
